cmd_dispatch_gen: RTL and testbench
===================================

Name: cmd_dispatch_gen

Overview:
Parametrised successor to the scope command dispatcher. It decodes 24-bit UART commands and drives the SPI master for gain, trigger-level and EEPROM accesses over N analog channels. It streams capture-dump bytes back through the UART response path and returns ACK/NACK/data bytes under a full response handshake. It adds an SPI timeout. It sits between the UART command aggregator, the SPI master, the capture unit and the UART transmitter.

Parameters:
NUM_CH, 3, number of analog channels (1..4); channel field width CH_W = max(1, $clog2(NUM_CH))
TIMEOUT_CYC, 1024, cycles to wait for SPI_done before aborting with NACK (>=2)
ACK_BYTE, 8'hA5, positive response byte
NACK_BYTE, 8'hEE, negative response byte

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cmd  in  24  command word; opcode cmd[19:16], gain cmd[12:10], channel cmd[8+CH_W-1:8], EEPROM addr cmd[13:8], data cmd[7:0]
cmd_rdy  in  1  command valid from aggregator
clr_cmd_rdy  out  1  one-cycle pulse, command consumed
resp_data  out  8  response byte to UART tx
send_resp  out  1  one-cycle pulse, resp_data valid
resp_sent  in  1  UART tx finished current byte
ss  out  NUM_CH+2  one-hot slave select; bit i = channel i gain, bit NUM_CH = trigger DAC, bit NUM_CH+1 = EEPROM; all-zero = none
wrt_SPI  out  1  one-cycle pulse, start SPI transaction
SPI_data  out  16  SPI transmit word
EEP_data  in  8  EEPROM read byte, valid with SPI_done
SPI_done  in  1  SPI transaction complete
start_dump  out  1  one-cycle pulse to capture unit
dump_channel  out  CH_W  channel to dump, held during DUMP
dump_byte  in  8  capture byte
dump_valid  in  1  dump_byte valid
dump_ready  out  1  dispatcher can accept dump_byte this cycle
dump_finished  in  1  capture unit has sent last byte
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst sampled high): state IDLE. All pulse outputs 0. ss=0, SPI_data=0, resp_data=0, dump_channel=0, dump_ready=0, busy=0, timeout counter=0.
- All outputs are registered.
- States: IDLE, SPI_WAIT, RD_WAIT, RESP_WAIT, DUMP, DUMP_WAIT.
- IDLE:
  - When cmd_rdy is sampled high at edge N, clr_cmd_rdy=1 in cycle N+1, plus the action below.
  - cmd_rdy is ignored in every other state and stays pending.
- Opcode 2 CONFIG_GAIN:
  - Channel >= NUM_CH: NACK path.
  - Otherwise ss=channel bit. SPI_data = {8'h13, G}, where G by ggg 0..7 = 02,05,09,14,28,46,6B,DD. Go to SPI_WAIT.
- Opcode 3 SET_TRIGGER: ss=trigger bit, SPI_data={8'h13, cmd[7:0]}. Go to SPI_WAIT.
- Opcode 8 WRITE_EEP: ss=EEPROM bit, SPI_data={2'b01, cmd[13:0]}. Go to SPI_WAIT.
- Opcode 9 READ_EEP: ss=EEPROM bit, SPI_data={2'b00, cmd[13:8], 8'h00}. Go to RD_WAIT.
- Opcode 1 DUMP:
  - Channel >= NUM_CH: NACK path.
  - Otherwise start_dump=1 and dump_channel latched. Go to DUMP.
- Other opcodes: NACK path.
- wrt_SPI pulses together with clr_cmd_rdy for SPI commands. ss and SPI_data are held until the SPI state exits, then ss=0.
- SPI_WAIT / RD_WAIT:
  - Timeout counter increments each cycle.
  - SPI_done sampled high: resp_data = ACK_BYTE (SPI_WAIT) or EEP_data (RD_WAIT), send_resp pulse next cycle, go to RESP_WAIT.
  - Counter reaches TIMEOUT_CYC-1 without SPI_done: ss=0, resp_data=NACK_BYTE, send_resp pulse, go to RESP_WAIT.
  - SPI_done arriving in the same cycle as expiry counts as success.
- NACK path: resp_data=NACK_BYTE, send_resp in the cycle after clr_cmd_rdy, go to RESP_WAIT.
- RESP_WAIT: hold resp_data. On resp_sent go to IDLE. The next command is accepted no earlier than the cycle after that.
- DUMP:
  - dump_ready=1.
  - dump_valid & dump_ready: resp_data=dump_byte, send_resp pulse next cycle, dump_ready=0, go to DUMP_WAIT.
  - dump_finished with no byte pending: go to IDLE; no ACK is sent.
- DUMP_WAIT:
  - On resp_sent, go to DUMP.
  - If dump_finished was seen while in DUMP_WAIT, latch it and go to IDLE on resp_sent instead.
- Exactly one send_resp per accepted command, except DUMP, which sends one per byte.
- Reset mid-operation returns to IDLE next cycle. No response is sent, and the pending cmd_rdy is not cleared.

Optional Feature:
TRIG_CFG_EN:
- Defined: adds output trig_cfg[5:0] (reset 6'h00) and opcode 4 SET_TRIG_CFG. That opcode writes trig_cfg <= cmd[5:0] and sends ACK_BYTE via RESP_WAIT, with no SPI traffic.
- Undefined: no trig_cfg port, and opcode 4 takes the NACK path.

Test Plan:
- cmd=24'h02_1400, NUM_CH=3 (ggg=5, ch0) -> clr_cmd_rdy, wrt_SPI, ss=5'b00001, SPI_data=16'h1346. SPI_done -> send_resp with resp_data=8'hA5.
- cmd=24'h09_2A00, SPI_done with EEP_data=8'h5C -> SPI_data=16'h2A00, ss=5'b10000, resp_data=8'h5C. A second cmd_rdy is held until after resp_sent.
- cmd=24'h02_0300 (ch3 with NUM_CH=3), and separately opcode 7 -> no wrt_SPI, resp_data=8'hEE.
- cmd=24'h03_0080 with SPI_done never asserted -> send_resp with 8'hEE exactly TIMEOUT_CYC cycles after wrt_SPI; ss=0.
- cmd=24'h01_0100 -> start_dump, dump_channel=1. Bytes 11,22,33 with resp_sent each -> three send_resp in order. dump_finished during the last DUMP_WAIT -> IDLE after resp_sent, no ACK.
- rst asserted during SPI_WAIT -> all outputs at reset values next cycle. With TRIG_CFG_EN: cmd=24'h04_002B -> trig_cfg=6'h2B, ACK.

Source files
------------

// File: rtl/cmd_dispatch_gen.sv
// Scope command dispatcher: decodes UART commands into SPI gain/trigger/EEPROM
// transactions or capture dumps and returns response bytes. Optional TRIG_CFG_EN adds trig_cfg.
module cmd_dispatch_gen #(
  parameter int         NUM_CH      = 3,
  parameter int         TIMEOUT_CYC = 1024,
  parameter logic [7:0] ACK_BYTE    = 8'hA5,
  parameter logic [7:0] NACK_BYTE   = 8'hEE,
  localparam int        CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [23:0]       cmd,
  input  logic              cmd_rdy,
  output logic              clr_cmd_rdy,
  output logic [7:0]        resp_data,
  output logic              send_resp,
  input  logic              resp_sent,
  output logic [NUM_CH+1:0] ss,
  output logic              wrt_SPI,
  output logic [15:0]       SPI_data,
  input  logic [7:0]        EEP_data,
  input  logic              SPI_done,
  output logic              start_dump,
  output logic [CH_W-1:0]   dump_channel,
  input  logic [7:0]        dump_byte,
  input  logic              dump_valid,
  output logic              dump_ready,
  input  logic              dump_finished,
  output logic              busy
`ifdef TRIG_CFG_EN
  ,
  output logic [5:0]        trig_cfg
`endif
);

  localparam int SS_W  = NUM_CH + 2;
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [SS_W-1:0]  TRIG_SEL = SS_W'(1) << NUM_CH;
  localparam logic [SS_W-1:0]  EEP_SEL  = SS_W'(1) << (NUM_CH + 1);

  typedef enum logic [2:0] {IDLE, SPI_WAIT, RD_WAIT, RESP_WAIT, DUMP, DUMP_WAIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             pend;      // response byte loaded, send_resp goes out next cycle
  logic             fin_seen;

  logic [3:0]       op;
  logic [CH_W-1:0]  ch;
  logic             ch_ok;
  logic             op_ok;
  logic [7:0]       gain_val;
  logic [SS_W-1:0]  ch_sel;
  logic             unused_cmd;

  assign unused_cmd = ^{cmd[23:20], cmd[15:14]};

  always_comb begin
    op       = cmd[19:16];
    ch       = cmd[8 +: CH_W];
    ch_ok    = (32'(ch) < 32'(NUM_CH));
    ch_sel   = SS_W'(1) << ch;
    gain_val = 8'h02;
    case (cmd[12:10])
      3'd0: gain_val = 8'h02;
      3'd1: gain_val = 8'h05;
      3'd2: gain_val = 8'h09;
      3'd3: gain_val = 8'h14;
      3'd4: gain_val = 8'h28;
      3'd5: gain_val = 8'h46;
      3'd6: gain_val = 8'h6B;
      3'd7: gain_val = 8'hDD;
      default: gain_val = 8'h02;
    endcase
    case (op)
      4'd1, 4'd2:       op_ok = ch_ok;
      4'd3, 4'd8, 4'd9: op_ok = 1'b1;
`ifdef TRIG_CFG_EN
      4'd4:             op_ok = 1'b1;
`endif
      default:          op_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      pend         <= 1'b0;
      fin_seen     <= 1'b0;
      clr_cmd_rdy  <= 1'b0;
      resp_data    <= 8'h00;
      send_resp    <= 1'b0;
      ss           <= '0;
      wrt_SPI      <= 1'b0;
      SPI_data     <= 16'h0000;
      start_dump   <= 1'b0;
      dump_channel <= '0;
      dump_ready   <= 1'b0;
      busy         <= 1'b0;
`ifdef TRIG_CFG_EN
      trig_cfg     <= 6'h00;
`endif
    end else begin
      clr_cmd_rdy <= 1'b0;
      wrt_SPI     <= 1'b0;
      send_resp   <= 1'b0;
      start_dump  <= 1'b0;
      case (state)
        IDLE: if (cmd_rdy) begin
          clr_cmd_rdy <= 1'b1;
          busy        <= 1'b1;
          if (!op_ok) begin
            resp_data <= NACK_BYTE;
            pend      <= 1'b1;
            state     <= RESP_WAIT;
          end else begin
            case (op)
              4'd1: begin
                start_dump   <= 1'b1;
                dump_channel <= ch;
                dump_ready   <= 1'b1;
                fin_seen     <= 1'b0;
                state        <= DUMP;
              end
              4'd2: begin
                ss       <= ch_sel;
                SPI_data <= {8'h13, gain_val};
                wrt_SPI  <= 1'b1;
                state    <= SPI_WAIT;
              end
              4'd3: begin
                ss       <= TRIG_SEL;
                SPI_data <= {8'h13, cmd[7:0]};
                wrt_SPI  <= 1'b1;
                state    <= SPI_WAIT;
              end
              4'd8: begin
                ss       <= EEP_SEL;
                SPI_data <= {2'b01, cmd[13:0]};
                wrt_SPI  <= 1'b1;
                state    <= SPI_WAIT;
              end
              4'd9: begin
                ss       <= EEP_SEL;
                SPI_data <= {2'b00, cmd[13:8], 8'h00};
                wrt_SPI  <= 1'b1;
                state    <= RD_WAIT;
              end
`ifdef TRIG_CFG_EN
              4'd4: begin
                trig_cfg  <= cmd[5:0];
                resp_data <= ACK_BYTE;
                pend      <= 1'b1;
                state     <= RESP_WAIT;
              end
`endif
              default: begin
                resp_data <= NACK_BYTE;
                pend      <= 1'b1;
                state     <= RESP_WAIT;
              end
            endcase
          end
        end
        SPI_WAIT, RD_WAIT: begin
          // SPI_done wins over a timeout expiring in the same cycle
          if (SPI_done) begin
            resp_data <= (state == RD_WAIT) ? EEP_data : ACK_BYTE;
            send_resp <= 1'b1;
            ss        <= '0;
            cnt       <= '0;
            state     <= RESP_WAIT;
          end else if (cnt == CNT_LAST) begin
            resp_data <= NACK_BYTE;
            send_resp <= 1'b1;
            ss        <= '0;
            cnt       <= '0;
            state     <= RESP_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP_WAIT: begin
          if (pend) begin
            send_resp <= 1'b1;
            pend      <= 1'b0;
          end else if (resp_sent) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        DUMP: begin
          if (dump_valid && dump_ready) begin
            resp_data  <= dump_byte;
            send_resp  <= 1'b1;
            dump_ready <= 1'b0;
            fin_seen   <= dump_finished;
            state      <= DUMP_WAIT;
          end else if (dump_finished) begin
            dump_ready <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        DUMP_WAIT: begin
          if (resp_sent) begin
            if (fin_seen || dump_finished) begin
              fin_seen <= 1'b0;
              busy     <= 1'b0;
              state    <= IDLE;
            end else begin
              dump_ready <= 1'b1;
              state      <= DUMP;
            end
          end else if (dump_finished) begin
            fin_seen <= 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_dispatch_gen.sv
// Directed bench for cmd_dispatch_gen: vector table for single commands plus
// hand sequences for pending commands, timeout, dump streaming and reset.
module tb_cmd_dispatch_gen;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp_data;
  logic        send_resp;
  logic        resp_sent;
  logic [4:0]  ss;
  logic        wrt_SPI;
  logic [15:0] SPI_data;
  logic [7:0]  EEP_data;
  logic        SPI_done;
  logic        start_dump;
  logic [1:0]  dump_channel;
  logic [7:0]  dump_byte;
  logic        dump_valid;
  logic        dump_ready;
  logic        dump_finished;
  logic        busy;
`ifdef TRIG_CFG_EN
  logic [5:0]  trig_cfg;
`endif

  cmd_dispatch_gen #(.NUM_CH(3), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .resp_data(resp_data), .send_resp(send_resp), .resp_sent(resp_sent),
    .ss(ss), .wrt_SPI(wrt_SPI), .SPI_data(SPI_data), .EEP_data(EEP_data),
    .SPI_done(SPI_done), .start_dump(start_dump), .dump_channel(dump_channel),
    .dump_byte(dump_byte), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_finished(dump_finished), .busy(busy)
`ifdef TRIG_CFG_EN
    , .trig_cfg(trig_cfg)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [23:0] cmd;
    logic        spi;
    logic [4:0]  ss;
    logic [15:0] sdata;
    logic [7:0]  eep;
    logic [7:0]  resp;
  } vec_t;

  vec_t vt [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    logic [7:0] db [3];
    int k;
    db[0] = 8'h11; db[1] = 8'h22; db[2] = 8'h33;

    vt[0] = '{24'h02_1400, 1'b1, 5'b00001, 16'h1346, 8'h00, 8'hA5};
    vt[1] = '{24'h02_1E00, 1'b1, 5'b00100, 16'h13DD, 8'h00, 8'hA5};
    vt[2] = '{24'h02_0100, 1'b1, 5'b00010, 16'h1302, 8'h00, 8'hA5};
    vt[3] = '{24'h03_0080, 1'b1, 5'b01000, 16'h1380, 8'h00, 8'hA5};
    vt[4] = '{24'h08_3F5A, 1'b1, 5'b10000, 16'h7F5A, 8'h00, 8'hA5};
    vt[5] = '{24'h09_2A00, 1'b1, 5'b10000, 16'h2A00, 8'h5C, 8'h5C};
    vt[6] = '{24'h02_0300, 1'b0, 5'b00000, 16'h0000, 8'h00, 8'hEE};
    vt[7] = '{24'h07_0000, 1'b0, 5'b00000, 16'h0000, 8'h00, 8'hEE};
`ifdef TRIG_CFG_EN
    vt[8] = '{24'h04_002B, 1'b0, 5'b00000, 16'h0000, 8'h00, 8'hA5};
`else
    vt[8] = '{24'h04_002B, 1'b0, 5'b00000, 16'h0000, 8'h00, 8'hEE};
`endif
    vt[9] = '{24'h01_0300, 1'b0, 5'b00000, 16'h0000, 8'h00, 8'hEE};

    rst = 1'b1; cmd = '0; cmd_rdy = 1'b0; resp_sent = 1'b0; EEP_data = '0;
    SPI_done = 1'b0; dump_byte = '0; dump_valid = 1'b0; dump_finished = 1'b0;
    tick(); tick();
    chk("rst_clr", 32'(clr_cmd_rdy), 32'(0));
    chk("rst_send", 32'(send_resp), 32'(0));
    chk("rst_ss", 32'(ss), 32'(0));
    chk("rst_spidata", 32'(SPI_data), 32'(0));
    chk("rst_resp", 32'(resp_data), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_dready", 32'(dump_ready), 32'(0));
`ifdef TRIG_CFG_EN
    chk("rst_trig_cfg", 32'(trig_cfg), 32'(0));
`endif
    rst = 1'b0;
    tick();

    // single-command vectors
    for (int i = 0; i < 10; i++) begin
      cmd = vt[i].cmd; cmd_rdy = 1'b1;
      tick();
      cmd_rdy = 1'b0;
      chk($sformatf("v%0d_clr", i), 32'(clr_cmd_rdy), 32'(1));
      chk($sformatf("v%0d_wrt", i), 32'(wrt_SPI), 32'(vt[i].spi));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(1));
      if (vt[i].spi) begin
        chk($sformatf("v%0d_ss", i), 32'(ss), 32'(vt[i].ss));
        chk($sformatf("v%0d_spidata", i), 32'(SPI_data), 32'(vt[i].sdata));
        EEP_data = vt[i].eep; SPI_done = 1'b1;
        tick();
        SPI_done = 1'b0;
        chk($sformatf("v%0d_ss_off", i), 32'(ss), 32'(0));
      end else begin
        tick();
        chk($sformatf("v%0d_nowrt", i), 32'(wrt_SPI), 32'(0));
      end
      chk($sformatf("v%0d_send", i), 32'(send_resp), 32'(1));
      chk($sformatf("v%0d_resp", i), 32'(resp_data), 32'(vt[i].resp));
      resp_sent = 1'b1;
      tick();
      resp_sent = 1'b0;
      chk($sformatf("v%0d_send_off", i), 32'(send_resp), 32'(0));
      chk($sformatf("v%0d_idle", i), 32'(busy), 32'(0));
    end
`ifdef TRIG_CFG_EN
    chk("trig_cfg", 32'(trig_cfg), 32'(6'h2B));
`endif

    // second command stays pending until the read response is retired
    cmd = 24'h09_2A00; cmd_rdy = 1'b1;
    tick();
    chk("hold_clr0", 32'(clr_cmd_rdy), 32'(1));
    cmd = 24'h02_1400;
    tick(); chk("hold_clr_a", 32'(clr_cmd_rdy), 32'(0));
    tick(); chk("hold_clr_b", 32'(clr_cmd_rdy), 32'(0));
    EEP_data = 8'h5C; SPI_done = 1'b1;
    tick();
    SPI_done = 1'b0;
    chk("hold_resp", 32'(resp_data), 32'(8'h5C));
    chk("hold_send", 32'(send_resp), 32'(1));
    tick(); chk("hold_clr_c", 32'(clr_cmd_rdy), 32'(0));
    resp_sent = 1'b1;
    tick();
    resp_sent = 1'b0;
    chk("hold_clr_d", 32'(clr_cmd_rdy), 32'(0));
    tick();
    cmd_rdy = 1'b0;
    chk("hold_clr_take", 32'(clr_cmd_rdy), 32'(1));
    chk("hold_wrt", 32'(wrt_SPI), 32'(1));
    chk("hold_spidata2", 32'(SPI_data), 32'(16'h1346));
    SPI_done = 1'b1;
    tick();
    SPI_done = 1'b0;
    chk("hold_ack2", 32'(resp_data), 32'(8'hA5));
    resp_sent = 1'b1; tick(); resp_sent = 1'b0;

    // SPI timeout: NACK exactly TO cycles after wrt_SPI
    cmd = 24'h03_0080; cmd_rdy = 1'b1;
    tick();
    cmd_rdy = 1'b0;
    chk("to_wrt", 32'(wrt_SPI), 32'(1));
    k = 0;
    while (!send_resp && k < 4 * TO) begin
      tick();
      k++;
    end
    chk("to_latency", 32'(k), 32'(TO));
    chk("to_resp", 32'(resp_data), 32'(8'hEE));
    chk("to_ss", 32'(ss), 32'(0));
    resp_sent = 1'b1; tick(); resp_sent = 1'b0;
    chk("to_idle", 32'(busy), 32'(0));

    // dump of channel 1, finish flagged during the last DUMP_WAIT
    cmd = 24'h01_0100; cmd_rdy = 1'b1;
    tick();
    cmd_rdy = 1'b0;
    chk("dmp_start", 32'(start_dump), 32'(1));
    chk("dmp_ch", 32'(dump_channel), 32'(1));
    chk("dmp_ready", 32'(dump_ready), 32'(1));
    chk("dmp_nowrt", 32'(wrt_SPI), 32'(0));
    for (int b = 0; b < 3; b++) begin
      dump_byte = db[b]; dump_valid = 1'b1;
      tick();
      dump_valid = 1'b0;
      chk($sformatf("dmp%0d_send", b), 32'(send_resp), 32'(1));
      chk($sformatf("dmp%0d_byte", b), 32'(resp_data), 32'(db[b]));
      chk($sformatf("dmp%0d_nready", b), 32'(dump_ready), 32'(0));
      if (b == 2) begin
        dump_finished = 1'b1;
        tick();
        dump_finished = 1'b0;
        chk("dmp_wait_busy", 32'(busy), 32'(1));
      end
      resp_sent = 1'b1; tick(); resp_sent = 1'b0;
      if (b == 2) chk("dmp_done_idle", 32'(busy), 32'(0));
      else        chk($sformatf("dmp%0d_ready", b), 32'(dump_ready), 32'(1));
    end
    k = 0;
    for (int j = 0; j < 5; j++) begin
      tick();
      if (send_resp) k++;
    end
    chk("dmp_no_ack", 32'(k), 32'(0));

    // dump ends with no bytes
    cmd = 24'h01_0200; cmd_rdy = 1'b1;
    tick();
    cmd_rdy = 1'b0;
    chk("dmp0_ch", 32'(dump_channel), 32'(2));
    dump_finished = 1'b1;
    tick();
    dump_finished = 1'b0;
    chk("dmp0_idle", 32'(busy), 32'(0));
    chk("dmp0_nosend", 32'(send_resp), 32'(0));

    // reset in SPI_WAIT with another command pending
    cmd = 24'h02_1400; cmd_rdy = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("mrst_ss", 32'(ss), 32'(0));
    chk("mrst_spidata", 32'(SPI_data), 32'(0));
    chk("mrst_busy", 32'(busy), 32'(0));
    chk("mrst_clr", 32'(clr_cmd_rdy), 32'(0));
    chk("mrst_send", 32'(send_resp), 32'(0));
    chk("mrst_resp", 32'(resp_data), 32'(0));
`ifdef TRIG_CFG_EN
    chk("mrst_trig_cfg", 32'(trig_cfg), 32'(0));
`endif
    rst = 1'b0; cmd_rdy = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
